dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the core's load/store port.
- Accepts one request at a time over a valid/ready request channel.
- Performs the word access after a configurable number of wait states.
- Returns read data and error status over a valid/ready response channel.
- Lets the core be verified against a realistic multi-cycle, back-pressuring data memory instead of an ideal zero-latency array.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the backing array.
- BASE_ADDR, 32'h0000_0000, byte address of word 0. Must be word aligned.
- WAIT_CYCLES, 2, wait states between request accept and memory access. Legal range 0..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, lane-aligned.
- req_be  in  4  byte enables for stores; bit i enables byte lane i. Ignored for loads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  core accepts the response.
- rsp_rdata  out  32  load data. 0 for stores and for errors.
- rsp_err  out  1  request was misaligned or out of range.

Behaviour:
- One clock domain. rst is asynchronous, active-high.
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
- The memory array is not cleared by reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - Accept on req_valid && req_ready at edge T. Capture we, addr, wdata, be.
  - If WAIT_CYCLES>0: go to WAIT and load counter with WAIT_CYCLES-1.
  - If WAIT_CYCLES=0: perform the access at the same edge T and go to RESP.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle.
  - When counter=0: perform the access at that edge and go to RESP.
- Access edge timing:
  - The access edge is the WAIT_CYCLES-th edge after T (T itself when WAIT_CYCLES=0).
  - rsp_valid goes high at that edge, so it is first visible in the cycle after it.
  - Latency from accept to rsp_valid = WAIT_CYCLES+1 cycles.
- Error check on captured address:
  - err if addr[1:0]!=0.
  - err if addr<BASE_ADDR.
  - err if (addr-BASE_ADDR)>>2 >= DEPTH_WORDS.
  - Use 32-bit unsigned subtraction and compare.
- Access:
  - Load, no error: rsp_rdata = full word at the index.
  - Store, no error: only lanes with be[i]=1 are written. rsp_rdata=0.
  - Store with be=4'b0000 is a legal no-op with rsp_err=0.
  - Any error: no array write, rsp_rdata=0, rsp_err=1.
- RESP:
  - rsp_valid=1. rsp_rdata and rsp_err stay stable until rsp_valid && rsp_ready.
  - On that handshake edge: rsp_valid←0, go to IDLE, req_ready←1.
  - The next request can be accepted in the following cycle, giving at most one transaction per WAIT_CYCLES+2 cycles.
- req_ready=0 throughout WAIT and RESP. A req_valid asserted then is not captured and must be held by the core (standard valid/ready).
- Only one transaction is outstanding; there is no queue.
- rst asserted mid-transaction:
  - Immediately forces IDLE and the reset output values.
  - A pending store is abandoned. An access edge coincident with rst assertion does not write.
- Load data is taken at the access edge; a store to the same word cannot interleave because only one request is outstanding.

Decomposition:
- Shared package dmem_pkg:
  - state enum {IDLE, WAIT, RESP}.
  - WORD_BYTES=4.
  - Address-to-index helper function.
  - Error-code constants, reserved for future multi-bit error.
- One sub-module, dmem_array:
  - DEPTH_WORDS x 32 synchronous array.
  - Byte-enable write port and registered read on the same access strobe.
  - No reset.
- Top dmem_responder contains the FSM, counter, capture registers and error logic.

Test Plan:
- Store 0xDEADBEEF to 0x10 with be=4'hF, then load from 0x10, rsp_ready=1 (default params) → each rsp_valid appears 3 cycles after accept. Load returns rsp_rdata=0xDEADBEEF, rsp_err=0.
- Store 0x0000AA00 to 0x10 with be=4'b0010, then load 0x10 → 0xDEADAAEF. Store 0x12345678 with be=0 → load still returns 0xDEADAAEF, err=0.
- Load 0x12 (misaligned) and load 0x1000 (index 1024, out of range) → rsp_err=1, rsp_rdata=0. Store 0x11223344 to 0x1000 → err=1 and no array location changes.
- Load with rsp_ready held low for 5 cycles while req_valid is held with a new request → rsp_valid, rsp_rdata and rsp_err stable, req_ready=0. The second request is accepted exactly one cycle after the response handshake.
- Store 0xCAFEF00D to 0x20 with rst pulsed during WAIT → rsp_valid=0 and req_ready=1 right after reset. A subsequent load 0x20 returns the pre-store value.
- WAIT_CYCLES=0 build: back-to-back loads with rsp_ready=1 → rsp_valid the cycle after accept, one transaction every 2 cycles.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned WORD_BYTES  = 4;
    localparam int unsigned BE_W        = WORD_BYTES;
    localparam int unsigned WORD_SHIFT  = $clog2(WORD_BYTES);
    localparam int unsigned CNT_W       = 4;

    // Error codes; the external port only reports non-zero as rsp_err today.
    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_RANGE    = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } dmem_req_t;

    // Word index relative to the array base (unsigned 32-bit wrap on underflow).
    function automatic logic [ADDR_W-1:0] addr_to_index(input logic [ADDR_W-1:0] addr,
                                                        input logic [ADDR_W-1:0] base);
        return (addr - base) >> WORD_SHIFT;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-wide synchronous backing store with byte-lane write enables.
// Read and write share one access strobe; no reset on contents or read data.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned IDX_W       = 10
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [BE_W-1:0]   be,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // Read returns the pre-write contents of the addressed word.
    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[idx];
            if (we) begin
                for (int b = 0; b < int'(BE_W); b++) begin
                    if (be[b]) begin
                        mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one outstanding request, programmable
// wait states, valid/ready on both request and response channels.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned       DEPTH_WORDS = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned       WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    dmem_req_t         req_q, acc_req_c;
    logic              accept_c;
    logic              access_c;
    logic              req_ready_d;
    logic              rsp_valid_d;
    logic [1:0]        acc_code_c;
    logic              rd_gate_q;
    logic [DATA_W-1:0] arr_rdata;

    assign accept_c = req_valid && req_ready;

    // With zero wait states the access uses the live request at the accept edge.
    always_comb begin
        acc_req_c = req_q;
        if (state_q == IDLE) begin
            acc_req_c.we    = req_we;
            acc_req_c.addr  = req_addr;
            acc_req_c.wdata = req_wdata;
            acc_req_c.be    = req_be;
        end
    end

    always_comb begin
        acc_code_c = ERR_NONE;
        if (acc_req_c.addr[WORD_SHIFT-1:0] != '0) begin
            acc_code_c = ERR_MISALIGN;
        end else if ((acc_req_c.addr < BASE_ADDR) ||
                     (addr_to_index(acc_req_c.addr, BASE_ADDR) >= DEPTH_WORDS)) begin
            acc_code_c = ERR_RANGE;
        end
    end

    // Next-state and registered-output targets.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        access_c    = 1'b0;
        req_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    if (WAIT_CYCLES == 0) begin
                        access_c = 1'b1;
                        state_d  = RESP;
                    end else begin
                        cnt_d    = CNT_LOAD;
                        state_d  = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    access_c = 1'b1;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        req_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_ready <= req_ready_d;
            rsp_valid <= rsp_valid_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q <= '0;
        end else if (accept_c) begin
            req_q.we    <= req_we;
            req_q.addr  <= req_addr;
            req_q.wdata <= req_wdata;
            req_q.be    <= req_be;
        end
    end

    // Response status latched at the access edge, cleared on handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_err   <= 1'b0;
            rd_gate_q <= 1'b0;
        end else if (access_c) begin
            rsp_err   <= (acc_code_c != ERR_NONE);
            rd_gate_q <= (acc_code_c == ERR_NONE) && !acc_req_c.we;
        end else if (rsp_valid && rsp_ready) begin
            rsp_err   <= 1'b0;
            rd_gate_q <= 1'b0;
        end
    end

    // Array read data is registered; the gate flop zeroes it for stores/errors.
    assign rsp_rdata = rd_gate_q ? arr_rdata : '0;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk   (clk),
        .en    (access_c && !rst),
        .we    (acc_req_c.we && (acc_code_c == ERR_NONE)),
        .idx   (IDX_W'(addr_to_index(acc_req_c.addr, BASE_ADDR))),
        .be    (acc_req_c.be),
        .wdata (acc_req_c.wdata),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against a word-array model,
// plus a zero-wait-state instance for back-to-back throughput.
module tb_dmem_responder;

    localparam int unsigned DEPTH  = 1024;
    localparam int unsigned WAITC  = 2;
    localparam int unsigned DEPTH0 = 64;
    localparam logic [31:0] BASE0  = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    logic        req_valid0, req_ready0, req_we0;
    logic [31:0] req_addr0, req_wdata0;
    logic [3:0]  req_be0;
    logic        rsp_valid0, rsp_ready0, rsp_err0;
    logic [31:0] rsp_rdata0;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem_m  [DEPTH];
    logic [31:0] mem0_m [DEPTH0];
    logic [31:0] last_rdata;
    logic        last_err;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [31:0] exp_rd;
        logic        exp_err;
    } op_t;
    op_t ops0[$];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .WAIT_CYCLES(WAITC)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH0), .BASE_ADDR(BASE0), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
        .req_addr(req_addr0), .req_wdata(req_wdata0), .req_be(req_be0),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
        .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // An address is legal if word aligned and inside [base, base + 4*depth).
    function automatic logic ref_err(input logic [31:0] a, input longint base, input longint depth);
        longint la;
        la = longint'({32'b0, a});
        return (a % 4 != 0) || (la < base) || (la >= base + 4 * depth);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // One full transaction on the main instance, compared with the model.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] be, input int hold);
        int          lat;
        logic        exp_err;
        logic [31:0] exp_rd;
        int          idx;
        exp_err = ref_err(addr, 0, DEPTH);
        exp_rd  = 32'h0;
        idx     = int'(addr / 4);
        if (!exp_err) begin
            if (we) mem_m[idx] = merge(mem_m[idx], wd, be);
            else    exp_rd = mem_m[idx];
        end
        req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
        req_valid = 1'b1;
        rsp_ready = (hold == 0);
        lat = 0;
        while (!req_ready && lat < 50) begin step(); lat++; end
        check("req_ready_before_accept", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 50) begin step(); lat++; end
        check("rsp_latency", 32'(lat), 32'(WAITC + 1));
        last_rdata = rsp_rdata;
        last_err   = rsp_err;
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_rdata", rsp_rdata, last_rdata);
            check("hold_ready", 32'(req_ready), 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        check("rsp_rdata", last_rdata, exp_rd);
        check("rsp_err", 32'(last_err), 32'(exp_err));
        step();
        check("post_hs_valid", 32'(rsp_valid), 32'd0);
        check("post_hs_ready", 32'(req_ready), 32'd1);
    endtask

    task automatic add_op0(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] be);
        op_t o;
        int  idx;
        o.we = we; o.addr = addr; o.wd = wd; o.be = be;
        o.exp_err = ref_err(addr, longint'(BASE0), DEPTH0);
        o.exp_rd  = 32'h0;
        if (!o.exp_err) begin
            idx = int'((addr - BASE0) / 4);
            if (we) mem0_m[idx] = merge(mem0_m[idx], wd, be);
            else    o.exp_rd = mem0_m[idx];
        end
        ops0.push_back(o);
    endtask

    initial begin
        int          k;
        logic [31:0] a;
        logic [31:0] pre20;
        rst = 1'b1;
        req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_be = 0; rsp_ready = 0;
        req_valid0 = 0; req_we0 = 0; req_addr0 = 0; req_wdata0 = 0; req_be0 = 0; rsp_ready0 = 0;
        repeat (3) step();
        rst = 1'b0;
        step();
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'h0);
        check("reset_rsp_err", 32'(rsp_err), 32'd0);

        // Fill the whole array so every later load has a defined value.
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem_m[i] = 32'h0;
            txn(1'b1, 32'(i * 4), $urandom, 4'hF, 0);
        end

        txn(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0);
        txn(1'b0, 32'h10, 32'h0, 4'h0, 0);
        check("ld_deadbeef", last_rdata, 32'hDEAD_BEEF);
        txn(1'b1, 32'h10, 32'h0000_AA00, 4'b0010, 0);
        txn(1'b0, 32'h10, 32'h0, 4'h0, 1);
        check("ld_lane1", last_rdata, 32'hDEAD_AAEF);
        txn(1'b1, 32'h10, 32'h1234_5678, 4'b0000, 0);
        check("st_be0_err", 32'(last_err), 32'd0);
        txn(1'b0, 32'h10, 32'h0, 4'h0, 0);
        check("ld_after_be0", last_rdata, 32'hDEAD_AAEF);
        txn(1'b0, 32'h12, 32'h0, 4'h0, 0);
        check("ld_misalign_err", 32'(last_err), 32'd1);
        txn(1'b0, 32'h1000, 32'h0, 4'h0, 0);
        check("ld_oor_err", 32'(last_err), 32'd1);
        check("ld_oor_rdata", last_rdata, 32'h0);
        txn(1'b1, 32'h1000, 32'h1122_3344, 4'hF, 2);
        check("st_oor_err", 32'(last_err), 32'd1);
        txn(1'b0, 32'hFFC, 32'h0, 4'h0, 0);
        check("ld_last_word_err", 32'(last_err), 32'd0);

        // Back-pressure with a second request held on the request channel.
        req_we = 0; req_addr = 32'h10; req_valid = 1'b1; rsp_ready = 1'b0;
        step();
        req_addr = 32'h14;
        k = 0;
        while (!rsp_valid && k < 50) begin step(); k++; end
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rdata", rsp_rdata, 32'hDEAD_AAEF);
            check("bp_err", 32'(rsp_err), 32'd0);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        check("bp_hs_valid", 32'(rsp_valid), 32'd0);
        check("bp_hs_ready", 32'(req_ready), 32'd1);
        step();
        check("bp_second_accepted", 32'(req_ready), 32'd0);
        req_valid = 1'b0;
        k = 1;
        while (!rsp_valid && k < 50) begin step(); k++; end
        check("bp_second_latency", 32'(k), 32'(WAITC + 1));
        check("bp_second_rdata", rsp_rdata, mem_m[5]);
        step();

        // Reset in the middle of a store abandons it.
        pre20 = mem_m[8];
        req_we = 1; req_addr = 32'h20; req_wdata = 32'hCAFE_F00D; req_be = 4'hF;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_mid_valid", 32'(rsp_valid), 32'd0);
        check("rst_mid_ready", 32'(req_ready), 32'd1);
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("rst_no_rsp", 32'(rsp_valid), 32'd0);
            step();
        end
        txn(1'b0, 32'h20, 32'h0, 4'h0, 0);
        check("rst_pre_store_value", last_rdata, pre20);

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            k = int'($urandom_range(0, 9));
            if (k < 7)       a = 32'($urandom_range(0, DEPTH - 1)) * 4;
            else if (k == 7) a = 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
            else             a = $urandom | 32'h0000_1000;
            txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), int'($urandom_range(0, 3)));
        end

        // Full readback confirms no stray writes anywhere.
        for (int i = 0; i < int'(DEPTH); i++) txn(1'b0, 32'(i * 4), 32'h0, 4'h0, 0);

        // Zero-wait-state instance: back-to-back with rsp_ready tied high.
        for (int i = 0; i < int'(DEPTH0); i++) mem0_m[i] = 32'h0;
        for (int i = 0; i < 4; i++) add_op0(1'b1, BASE0 + 32'(i * 4), $urandom, 4'hF);
        add_op0(1'b1, BASE0 + 32'h0FC, $urandom, 4'hF);
        add_op0(1'b1, BASE0 + 32'h4, 32'h00AB_0000, 4'b0100);
        for (int i = 0; i < 4; i++) add_op0(1'b0, BASE0 + 32'(i * 4), 32'h0, 4'h0);
        add_op0(1'b0, BASE0 + 32'h0FC, 32'h0, 4'h0);
        add_op0(1'b0, BASE0 - 32'h4, 32'h0, 4'h0);
        add_op0(1'b0, BASE0 + 32'h100, 32'h0, 4'h0);
        add_op0(1'b1, BASE0 + 32'h100, 32'h5555_5555, 4'hF);
        add_op0(1'b0, BASE0 + 32'h2, 32'h0, 4'h0);
        add_op0(1'b0, BASE0 + 32'h0FC, 32'h0, 4'h0);

        k = 0;
        rsp_ready0 = 1'b1;
        req_we0 = ops0[0].we; req_addr0 = ops0[0].addr;
        req_wdata0 = ops0[0].wd; req_be0 = ops0[0].be;
        req_valid0 = 1'b1;
        for (int c = 1; c <= 2 * ops0.size() + 6 && k < ops0.size(); c++) begin
            step();
            check("b2b_ready_vs_valid", 32'(req_ready0), 32'(!rsp_valid0));
            if (rsp_valid0) begin
                check("b2b_rdata", rsp_rdata0, ops0[k].exp_rd);
                check("b2b_err", 32'(rsp_err0), 32'(ops0[k].exp_err));
                check("b2b_cycle", 32'(c), 32'(2 * k + 1));
                k++;
                if (k < ops0.size()) begin
                    req_we0 = ops0[k].we; req_addr0 = ops0[k].addr;
                    req_wdata0 = ops0[k].wd; req_be0 = ops0[k].be;
                end else begin
                    req_valid0 = 1'b0;
                end
            end
        end
        req_valid0 = 1'b0;
        check("b2b_count", 32'(k), 32'(ops0.size()));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
